// File: rtl/wr_arbiter.sv
// Round-robin write-port arbiter: NREQ requesters share one enable-register bank
// (reg_d_o -> flop d, reg_en_o -> flop en). Each owner may write at most MAX_BURST
// consecutive beats before the port is re-arbitrated.
// Optional macro WR_FIXED_PRIO_EN: the pointer stays at 0, so the lowest asserted index
// always wins each selection.

`ifndef WIDTH
`define WIDTH 8
`endif
`ifndef Enable
`define Enable 1'b1
`endif
`ifndef Disable
`define Disable 1'b0
`endif

module wr_arbiter #(
   parameter int unsigned NREQ      = 4,
   parameter int unsigned W         = `WIDTH,
   parameter int unsigned MAX_BURST = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NREQ-1:0]   req_i,
   input  logic [NREQ*W-1:0] din_i,
   output logic [NREQ-1:0]   gnt_o,
   output logic [W-1:0]      reg_d_o,
   output logic              reg_en_o,
   output logic              busy_o
);

   localparam int unsigned IdxW = $clog2(NREQ);
   localparam int unsigned CntW = $clog2(MAX_BURST + 1);
`ifdef WR_FIXED_PRIO_EN
   localparam bit FixedPrio = 1'b1;
`else
   localparam bit FixedPrio = 1'b0;
`endif

   typedef enum logic [0:0] {StIdle, StGrant} state_e;

   state_e          state_q, state_d;
   logic [IdxW-1:0] ptr_q, ptr_d;
   logic [IdxW-1:0] owner_q, owner_d;
   logic [CntW-1:0] burst_cnt_q, burst_cnt_d;
   logic [NREQ-1:0] gnt_q, gnt_d;
   logic [W-1:0]    reg_d_q, reg_d_d;

   logic [IdxW-1:0] owner_inc;
   logic [IdxW-1:0] ptr_rel;
   logic [IdxW-1:0] base;
   logic [IdxW-1:0] win;
   logic            win_vld;
   int              idx;

   // Winner search starts at the pointer the next release would use, so a release and
   // a fresh selection happen in the same cycle without a bubble.
   always_comb begin
      owner_inc = (owner_q == IdxW'(NREQ - 1)) ? '0 : owner_q + 1'b1;
      ptr_rel   = FixedPrio ? '0 : owner_inc;
      base      = (state_q == StGrant) ? ptr_rel : ptr_q;
      win       = '0;
      win_vld   = 1'b0;
      idx       = 0;
      for (int k = 0; k < int'(NREQ); k++) begin
         idx = int'(base) + k;
         if (idx >= int'(NREQ)) idx = idx - int'(NREQ);
         if (!win_vld && req_i[IdxW'(idx)]) begin
            win_vld = 1'b1;
            win     = IdxW'(idx);
         end
      end
   end

   // Next-state: keep the owner while it requests and the burst is not exhausted,
   // otherwise release and hand over to the next winner (possibly the same requester).
   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      owner_d     = owner_q;
      burst_cnt_d = burst_cnt_q;
      gnt_d       = gnt_q;
      reg_d_d     = reg_d_q;
      unique case (state_q)
         StIdle: begin
            gnt_d = '0;
            if (win_vld) begin
               state_d     = StGrant;
               owner_d     = win;
               gnt_d       = NREQ'(1) << win;
               reg_d_d     = din_i[win*W +: W];
               burst_cnt_d = CntW'(1);
            end
         end
         StGrant: begin
            if (req_i[owner_q] && (burst_cnt_q < CntW'(MAX_BURST))) begin
               burst_cnt_d = burst_cnt_q + 1'b1;
               reg_d_d     = din_i[owner_q*W +: W];
            end else begin
               ptr_d = ptr_rel;
               if (win_vld) begin
                  owner_d     = win;
                  gnt_d       = NREQ'(1) << win;
                  reg_d_d     = din_i[win*W +: W];
                  burst_cnt_d = CntW'(1);
               end else begin
                  state_d     = StIdle;
                  gnt_d       = '0;
                  burst_cnt_d = '0;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // State and output registers; reset clears outputs immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         ptr_q       <= '0;
         owner_q     <= '0;
         burst_cnt_q <= '0;
         gnt_q       <= '0;
         reg_d_q     <= '0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         owner_q     <= owner_d;
         burst_cnt_q <= burst_cnt_d;
         gnt_q       <= gnt_d;
         reg_d_q     <= reg_d_d;
      end
   end

   // Enable follows the registered grant, so it is never asserted without an owner.
   always_comb begin
      gnt_o    = gnt_q;
      reg_d_o  = reg_d_q;
      reg_en_o = (gnt_q != '0) ? `Enable : `Disable;
      busy_o   = (state_q == StGrant);
   end

endmodule

// File: tb/tb_wr_arbiter.sv
// Self-checking bench for wr_arbiter: behavioural model feeds a scoreboard queue,
// plus directed checks of the grant patterns, burst counting and async reset.

module tb_wr_arbiter;

   localparam int NREQ      = 4;
   localparam int W         = 8;
   localparam int MAX_BURST = 4;

   logic              clk;
   logic              rst_n;
   logic [NREQ-1:0]   req;
   logic [NREQ*W-1:0] din;
   logic [NREQ-1:0]   gnt;
   logic [W-1:0]      reg_d;
   logic              reg_en;
   logic              busy;

   wr_arbiter #(
      .NREQ      (NREQ),
      .W         (W),
      .MAX_BURST (MAX_BURST)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .req_i    (req),
      .din_i    (din),
      .gnt_o    (gnt),
      .reg_d_o  (reg_d),
      .reg_en_o (reg_en),
      .busy_o   (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [NREQ-1:0] gnt;
      logic [W-1:0]    d;
      logic            en;
      logic            busy;
   } exp_t;

   exp_t sb[$];

   int n_checks = 0;
   int n_pass   = 0;

   // Requester state: beats left, current data, data increment (0 = random)
   int         r_beats [NREQ];
   logic [W-1:0] r_data [NREQ];
   int         r_step  [NREQ];

   // Reference model state
   int              m_busy, m_ptr, m_own, m_cnt;
   logic [NREQ-1:0] m_gnt;
   logic [W-1:0]    m_regd;

   // Last observed DUT outputs, for directed checks
   logic [NREQ-1:0] obs_gnt;
   logic [W-1:0]    obs_regd;
   logic            obs_en;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic model_reset();
      m_busy = 0; m_ptr = 0; m_own = 0; m_cnt = 0; m_gnt = '0; m_regd = '0;
   endtask

   // One rising edge of the reference arbiter using the currently driven req/din.
   task automatic model_edge();
      int pick;
      if (!rst_n) begin
         model_reset();
         return;
      end
      if (m_busy != 0 && req[m_own] && m_cnt < MAX_BURST) begin
         m_cnt++;
         m_regd = din[m_own*W +: W];
         return;
      end
      if (m_busy != 0) begin
`ifdef WR_FIXED_PRIO_EN
         m_ptr = 0;
`else
         m_ptr = (m_own + 1) % NREQ;
`endif
      end
      pick = -1;
      for (int k = NREQ - 1; k >= 0; k--)
         if (req[(m_ptr + k) % NREQ]) pick = (m_ptr + k) % NREQ;
      if (pick >= 0) begin
         m_busy = 1; m_own = pick; m_cnt = 1;
         m_gnt  = '0;
         m_gnt[pick] = 1'b1;
         m_regd = din[pick*W +: W];
      end else begin
         m_busy = 0; m_cnt = 0; m_gnt = '0;
      end
   endtask

   // Drive one cycle of stimulus, predict, then compare after the edge.
   task automatic step();
      exp_t e;
      @(negedge clk);
      for (int i = 0; i < NREQ; i++) begin
         req[i] = (r_beats[i] > 0);
         din[i*W +: W] = r_data[i];
      end
      model_edge();
      e.gnt  = m_gnt;
      e.d    = m_regd;
      e.en   = (m_gnt != '0);
      e.busy = (m_busy != 0);
      sb.push_back(e);
      @(posedge clk);
      #1;
      obs_gnt  = gnt;
      obs_regd = reg_d;
      obs_en   = reg_en;
      if (sb.size() == 0) begin
         check_eq("sb_empty", 32'd0, 32'd1);
      end else begin
         e = sb.pop_front();
         check_eq("gnt", 32'(gnt), 32'(e.gnt));
         check_eq("reg_d", 32'(reg_d), 32'(e.d));
         check_eq("reg_en", 32'(reg_en), 32'(e.en));
         check_eq("busy", 32'(busy), 32'(e.busy));
         // Requesters advance on an observed grant
         for (int i = 0; i < NREQ; i++) begin
            if (e.gnt[i] && r_beats[i] > 0) begin
               r_beats[i]--;
               r_data[i] = (r_step[i] == 0) ? W'($urandom) : r_data[i] + W'(r_step[i]);
            end
         end
      end
   endtask

   task automatic clear_reqs();
      for (int i = 0; i < NREQ; i++) begin
         r_beats[i] = 0;
         r_step[i]  = 0;
         r_data[i]  = W'($urandom);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      req   = '0;
      din   = '0;
      clear_reqs();
      model_reset();

      // Reset state
      #12;
      check_eq("rst_gnt", 32'(gnt), 32'd0);
      check_eq("rst_en", 32'(reg_en), 32'd0);
      check_eq("rst_d", 32'(reg_d), 32'd0);
      check_eq("rst_busy", 32'(busy), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Burst limit: req0 and req1 held constantly
      r_beats[0] = 1000;
      r_beats[1] = 1000;
      for (int c = 0; c < 12; c++) begin
         step();
`ifdef WR_FIXED_PRIO_EN
         check_eq("burst_gnt", 32'(obs_gnt), 32'h1);
`else
         check_eq("burst_gnt", 32'(obs_gnt), (c >= 4 && c < 8) ? 32'h2 : 32'h1);
`endif
      end
      clear_reqs();
      step();
      check_eq("burst_idle_en", 32'(obs_en), 32'd0);

      // Single requester: 10, 20, 30 then drop
      r_beats[2] = 3;
      r_data[2]  = 8'd10;
      r_step[2]  = 10;
      for (int c = 1; c <= 3; c++) begin
         step();
         check_eq("single_d", 32'(obs_regd), 32'(c * 10));
         check_eq("single_en", 32'(obs_en), 32'd1);
      end
      step();
      check_eq("single_drop_en", 32'(obs_en), 32'd0);
      check_eq("single_drop_busy", 32'(busy), 32'd0);
      clear_reqs();

      // Wrap-around: ptr=3, req0/req1 only, then all four
      r_beats[0] = 1000;
      r_beats[1] = 1000;
      step();
      check_eq("wrap_first", 32'(obs_gnt), 32'h1);
      r_beats[2] = 1000;
      r_beats[3] = 1000;
      for (int c = 2; c <= 20; c++) begin
         step();
`ifdef WR_FIXED_PRIO_EN
         if (c % 4 == 1) check_eq("wrap_order", 32'(obs_gnt), 32'h1);
`else
         case (c)
            5:  check_eq("wrap_order1", 32'(obs_gnt), 32'h2);
            9:  check_eq("wrap_order2", 32'(obs_gnt), 32'h4);
            13: check_eq("wrap_order3", 32'(obs_gnt), 32'h8);
            17: check_eq("wrap_order0", 32'(obs_gnt), 32'h1);
            default: ;
         endcase
`endif
      end
      clear_reqs();
      step();

      // Sole requester at the burst limit: 9 beats continuous
      r_beats[3] = 9;
      for (int c = 0; c < 9; c++) begin
         step();
         check_eq("sole_gnt", 32'(obs_gnt), 32'h8);
         check_eq("sole_cnt", 32'(dut.burst_cnt_q), 32'((c % 4) + 1));
      end
      step();
      check_eq("sole_end_en", 32'(obs_en), 32'd0);

      // Move the pointer away from 0 before the reset test
      r_beats[2] = 1;
      step();
      step();

      // Reset mid-burst
      r_beats[1] = 1000;
      step();
      step();
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_eq("midrst_gnt", 32'(gnt), 32'd0);
      check_eq("midrst_en", 32'(reg_en), 32'd0);
      check_eq("midrst_d", 32'(reg_d), 32'd0);
      check_eq("midrst_busy", 32'(busy), 32'd0);
      model_reset();
      clear_reqs();
      step();
      step();
      rst_n = 1'b1;
      r_beats[1] = 5;
      r_beats[3] = 5;
      step();
      check_eq("postrst_first", 32'(obs_gnt), 32'h2);
      for (int c = 0; c < 12; c++) step();
      clear_reqs();
      step();

`ifdef WR_FIXED_PRIO_EN
      // Fixed priority: req0 wins every burst, req2 only after req0 drops
      r_beats[0] = 6;
      r_beats[2] = 6;
      for (int c = 0; c < 6; c++) begin
         step();
         check_eq("fixed_gnt0", 32'(obs_gnt), 32'h1);
      end
      step();
      check_eq("fixed_gnt2", 32'(obs_gnt), 32'h4);
      clear_reqs();
      step();
      step();
`endif

      check_eq("sb_drained", 32'(sb.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
